write_back_regfile: RTL and testbench
=====================================

WRITE_BACK_REGFILE -- requirements
Module: write_back_regfile

Interface
REQ-001 SHALL have parameter NREG, default 15, meaning the number of architectural 64-bit registers (ids 0..14); id 4'hF is RNONE.
REQ-002 SHALL have port clk_i  input  1  meaning the single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n_i  input  1  meaning the reset, asynchronous and active-low.
REQ-004 SHALL have port valid_i  input  1  meaning an instruction is presented for retirement this cycle; 0 means bubble.
REQ-005 SHALL have port icode_i  input  4  meaning the instruction code of the retiring instruction.
REQ-006 SHALL have port stat_i  input  3  meaning the upstream status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
REQ-007 SHALL have port dmem_error_i  input  1  meaning the memory-stage data access faulted.
REQ-008 SHALL have ports valE_i and valM_i  input  64 each  meaning the ALU result and the memory read data.
REQ-009 SHALL have ports dstE_i and dstM_i  input  4 each  meaning the destination register ids for valE and valM.
REQ-010 SHALL have ports srcA_i and srcB_i  input  4 each  meaning the decode-stage read register ids.
REQ-011 SHALL have ports valA_o and valB_o  output  64 each  meaning the read data for srcA_i and srcB_i.
REQ-012 SHALL have port stat_o  output  3  meaning the architectural processor status.
REQ-013 SHALL have port halted_o  output  1  meaning retirement is frozen (stat_o != AOK).
REQ-014 SHALL have port retired_o  output  64  meaning the count of retired instructions.

Function
REQ-015 SHALL compute the effective status as ADR when valid_i=1 and dmem_error_i=1, otherwise stat_i.
REQ-016 SHALL retire an instruction on a rising edge when valid_i=1, halted_o=0 and effective status=AOK.
REQ-017 SHALL, on retirement, write valE_i to register dstE_i when dstE_i != 4'hF and dstE_i < NREG.
REQ-018 SHALL, on retirement, write valM_i to register dstM_i when dstM_i != 4'hF and dstM_i < NREG.
REQ-019 SHALL, when dstE_i == dstM_i (both valid), store valM_i only (memory result wins, popq %rsp case).
REQ-020 SHALL increment retired_o by 1 on each retirement, wrapping modulo 2^64.
REQ-021 SHALL, on a rising edge with valid_i=1, halted_o=0 and effective status != AOK, latch the effective status into stat_o, set halted_o, and perform no register write and no count increment.
REQ-022 SHALL hold stat_o, halted_o, all registers and retired_o unchanged while halted_o=1, regardless of inputs, until reset.
REQ-023 SHALL ignore all inputs except srcA_i/srcB_i when valid_i=0 (bubble): no write, no count, no status change.
REQ-024 SHALL treat an effective status outside 1..4 as INS when latching (REQ-021).
REQ-025 SHALL drive valA_o/valB_o combinationally from the register array contents; ids 4'hF or >= NREG return 0.
REQ-026 SHALL NOT bypass same-cycle write data to valA_o/valB_o; new values appear after the writing edge.
REQ-027 SHALL treat icode_i only as informational; halt detection relies on stat_i=HLT from upstream.

Reset
REQ-028 SHALL, while rst_n_i=0, immediately force all registers to 0, stat_o=1 (AOK), halted_o=0, retired_o=0.
REQ-029 SHALL, on reset asserted mid-operation, discard any pending write of that cycle and resume retirement on the first rising edge after rst_n_i returns to 1.

Verification
REQ-030 SHALL verify: valid=1, stat=AOK, dstE=0, valE=0x2A, dstM=F -> next cycle srcA=0 gives valA_o=0x2A, retired_o=1.
REQ-031 SHALL verify: dstE=dstM=4, valE=0x10, valM=0x99, AOK -> register 4 reads 0x99.
REQ-032 SHALL verify: valid=1, AOK, dmem_error_i=1, dstE=3, valE=5 -> stat_o=3, halted_o=1, register 3 stays 0, retired_o unchanged; later AOK writes ignored.
REQ-033 SHALL verify: valid=1, stat=HLT -> stat_o=2, halted_o=1; after rst_n_i pulse low -> stat_o=1, all registers 0, retired_o=0.
REQ-034 SHALL verify: valid=0 with dstE=1, valE=7 -> register 1 stays 0, retired_o unchanged; srcB=F always gives valB_o=0.
REQ-035 SHALL verify: rst_n_i driven low between clock edges during a write -> outputs reset immediately without waiting for clk_i, written value absent.

Source files
------------

// File: rtl/write_back_regfile.sv
// Write-back stage with the architectural register file.
// Retires one instruction per cycle: it writes valE/valM to their destination
// registers and counts the retirement. A non-AOK status freezes the machine
// until reset. Read ports are combinational and never bypass same-cycle data.
module write_back_regfile #(
   parameter int NREG = 15
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        valid_i,
   input  logic [3:0]  icode_i,
   input  logic [2:0]  stat_i,
   input  logic        dmem_error_i,
   input  logic [63:0] valE_i,
   input  logic [63:0] valM_i,
   input  logic [3:0]  dstE_i,
   input  logic [3:0]  dstM_i,
   input  logic [3:0]  srcA_i,
   input  logic [3:0]  srcB_i,
   output logic [63:0] valA_o,
   output logic [63:0] valB_o,
   output logic [2:0]  stat_o,
   output logic        halted_o,
   output logic [63:0] retired_o
);

   typedef enum logic [2:0] {
      STAT_AOK = 3'd1,
      STAT_HLT = 3'd2,
      STAT_ADR = 3'd3,
      STAT_INS = 3'd4
   } stat_e;

   localparam logic [3:0] RNONE = 4'hF;

   logic [63:0] regs_q [NREG];
   logic [63:0] regs_d [NREG];
   stat_e       stat_q;
   stat_e       stat_d;
   logic [63:0] retired_q;
   logic [63:0] retired_d;

   logic [2:0]  eff_stat;
   logic        halted;
   logic        retire;
   logic        fault;

   // icode is informational only; halting relies on the upstream status.
   logic        unused_icode;
   assign unused_icode = ^icode_i;

   // An id addresses a real register only if it is not RNONE and in range.
   function automatic logic id_ok(input logic [3:0] id);
      return (id != RNONE) && (int'(id) < NREG);
   endfunction

   // Decide whether this cycle retires, faults, or does nothing.
   always_comb begin
      eff_stat = (valid_i && dmem_error_i) ? STAT_ADR : stat_i;
      halted   = (stat_q != STAT_AOK);
      retire   = valid_i && !halted && (eff_stat == STAT_AOK);
      fault    = valid_i && !halted && (eff_stat != STAT_AOK);
   end

   // Next-state for registers, status and retirement counter; valM is applied
   // after valE so that the memory result wins when both target one register.
   always_comb begin
      regs_d    = regs_q;
      stat_d    = stat_q;
      retired_d = retired_q;
      if (retire) begin
         if (id_ok(dstE_i)) regs_d[dstE_i] = valE_i;
         if (id_ok(dstM_i)) regs_d[dstM_i] = valM_i;
         retired_d = retired_q + 64'd1;
      end else if (fault) begin
         case (eff_stat)
            STAT_HLT: stat_d = STAT_HLT;
            STAT_ADR: stat_d = STAT_ADR;
            STAT_INS: stat_d = STAT_INS;
            default:  stat_d = STAT_INS;
         endcase
      end
   end

   // State registers; reset clears everything immediately, dropping any
   // write that was about to happen.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         regs_q    <= '{default: '0};
         stat_q    <= STAT_AOK;
         retired_q <= '0;
      end else begin
         regs_q    <= regs_d;
         stat_q    <= stat_d;
         retired_q <= retired_d;
      end
   end

   // Combinational read ports; RNONE and out-of-range ids read as zero.
   always_comb begin
      valA_o = id_ok(srcA_i) ? regs_q[srcA_i] : '0;
      valB_o = id_ok(srcB_i) ? regs_q[srcB_i] : '0;
   end

   assign stat_o    = stat_q;
   assign halted_o  = (stat_q != STAT_AOK);
   assign retired_o = retired_q;

endmodule

// File: tb/tb_write_back_regfile.sv
// Testbench for write_back_regfile: directed vectors, a behavioural model of
// the architectural state checked every cycle, plus literal expectations.
module tb_write_back_regfile;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        valid_i;
   logic [3:0]  icode_i;
   logic [2:0]  stat_i;
   logic        dmem_error_i;
   logic [63:0] valE_i;
   logic [63:0] valM_i;
   logic [3:0]  dstE_i;
   logic [3:0]  dstM_i;
   logic [3:0]  srcA_i;
   logic [3:0]  srcB_i;
   logic [63:0] valA_o;
   logic [63:0] valB_o;
   logic [2:0]  stat_o;
   logic        halted_o;
   logic [63:0] retired_o;

   write_back_regfile #(.NREG(15)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .icode_i(icode_i),
      .stat_i(stat_i), .dmem_error_i(dmem_error_i), .valE_i(valE_i), .valM_i(valM_i),
      .dstE_i(dstE_i), .dstM_i(dstM_i), .srcA_i(srcA_i), .srcB_i(srcB_i),
      .valA_o(valA_o), .valB_o(valB_o), .stat_o(stat_o), .halted_o(halted_o),
      .retired_o(retired_o)
   );

   always #5 clk_i = ~clk_i;

   int n_compared = 0;
   int n_mismatch = 0;
   bit checks_on  = 1'b0;

   // Model of the architectural state.
   logic [63:0] m_regs [15];
   logic [2:0]  m_stat;
   logic [63:0] m_retired;
   logic [2:0]  m_eff;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] m_read(input logic [3:0] id);
      return (id < 4'd15) ? m_regs[id] : 64'd0;
   endfunction

   // Model update: a retirement writes E then M and counts; a bad status halts.
   always @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         foreach (m_regs[i]) m_regs[i] = 64'd0;
         m_stat    = 3'd1;
         m_retired = 64'd0;
      end else if (valid_i && m_stat == 3'd1) begin
         m_eff = dmem_error_i ? 3'd3 : stat_i;
         if (m_eff == 3'd1) begin
            if (dstE_i < 4'd15) m_regs[dstE_i] = valE_i;
            if (dstM_i < 4'd15) m_regs[dstM_i] = valM_i;
            m_retired = m_retired + 64'd1;
         end else begin
            m_stat = (m_eff >= 3'd1 && m_eff <= 3'd4) ? m_eff : 3'd4;
         end
      end
   end

   // Every-cycle comparison of the DUT against the model.
   always @(negedge clk_i) begin
      if (checks_on) begin
         checkOutput("cyc_stat_o", 64'(stat_o), 64'(m_stat));
         checkOutput("cyc_halted_o", 64'(halted_o), 64'(m_stat != 3'd1));
         checkOutput("cyc_retired_o", retired_o, m_retired);
         checkOutput("cyc_valA_o", valA_o, m_read(srcA_i));
         checkOutput("cyc_valB_o", valB_o, m_read(srcB_i));
      end
   end

   // Present one instruction, let the next edge consume it, then go idle.
   task automatic applyStimulus(input logic v, input logic [2:0] st, input logic err,
                                input logic [3:0] de, input logic [63:0] ve,
                                input logic [3:0] dm, input logic [63:0] vm);
      valid_i = v; stat_i = st; dmem_error_i = err;
      dstE_i = de; valE_i = ve; dstM_i = dm; valM_i = vm;
      icode_i = 4'h6;
      @(posedge clk_i);
      #2;
      valid_i = 1'b0;
   endtask

   task automatic readA(input logic [3:0] id, input logic [63:0] exp, input string name);
      srcA_i = id;
      #1;
      checkOutput(name, valA_o, exp);
   endtask

   task automatic readB(input logic [3:0] id, input logic [63:0] exp, input string name);
      srcB_i = id;
      #1;
      checkOutput(name, valB_o, exp);
   endtask

   task automatic pulseReset();
      valid_i = 1'b0;
      rst_n_i = 1'b0;
      #2;
      rst_n_i = 1'b1;
   endtask

   initial begin
      rst_n_i = 1'b0; valid_i = 1'b0; icode_i = 4'h0; stat_i = 3'd1;
      dmem_error_i = 1'b0; valE_i = '0; valM_i = '0;
      dstE_i = 4'hF; dstM_i = 4'hF; srcA_i = 4'hF; srcB_i = 4'hF;
      #12;
      checkOutput("reset_stat", 64'(stat_o), 64'd1);
      checkOutput("reset_halted", 64'(halted_o), 64'd0);
      checkOutput("reset_retired", retired_o, 64'd0);
      @(posedge clk_i);
      #2;
      rst_n_i = 1'b1;
      checks_on = 1'b1;

      // Simple write of register 0.
      applyStimulus(1'b1, 3'd1, 1'b0, 4'd0, 64'h2A, 4'hF, 64'd0);
      readA(4'd0, 64'h2A, "wr_r0");
      checkOutput("wr_r0_retired", retired_o, 64'd1);

      // Same destination for E and M: memory result wins.
      applyStimulus(1'b1, 3'd1, 1'b0, 4'd4, 64'h10, 4'd4, 64'h99);
      readA(4'd4, 64'h99, "popq_r4");
      checkOutput("popq_retired", retired_o, 64'd2);

      // Dual write to different registers, then the top register id.
      applyStimulus(1'b1, 3'd1, 1'b0, 4'd5, 64'h55, 4'd6, 64'h66);
      readA(4'd5, 64'h55, "dual_r5");
      readB(4'd6, 64'h66, "dual_r6");
      applyStimulus(1'b1, 3'd1, 1'b0, 4'd14, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 64'd1);
      readA(4'd14, 64'hFFFF_FFFF_FFFF_FFFF, "top_r14");
      checkOutput("top_retired", retired_o, 64'd4);

      // Bubbles are ignored, even with a halt status on the wires.
      applyStimulus(1'b0, 3'd1, 1'b0, 4'd1, 64'd7, 4'hF, 64'd0);
      readA(4'd1, 64'd0, "bubble_r1");
      checkOutput("bubble_retired", retired_o, 64'd4);
      applyStimulus(1'b0, 3'd2, 1'b1, 4'd1, 64'd7, 4'd1, 64'd8);
      checkOutput("bubble_hlt_halted", 64'(halted_o), 64'd0);
      readB(4'hF, 64'd0, "rnone_B");

      // No same-cycle bypass: the old value is visible until the edge.
      valid_i = 1'b1; stat_i = 3'd1; dmem_error_i = 1'b0;
      dstE_i = 4'd2; valE_i = 64'h22; dstM_i = 4'hF;
      readA(4'd2, 64'd0, "nobypass_before");
      @(posedge clk_i);
      #2;
      valid_i = 1'b0;
      readA(4'd2, 64'h22, "nobypass_after");

      // Reset asserted between edges while a write is pending.
      valid_i = 1'b1; stat_i = 3'd1; dstE_i = 4'd7; valE_i = 64'h77; dstM_i = 4'hF;
      #1;
      rst_n_i = 1'b0;
      #1;
      checkOutput("midrst_stat", 64'(stat_o), 64'd1);
      checkOutput("midrst_retired", retired_o, 64'd0);
      readA(4'd0, 64'd0, "midrst_r0");
      @(posedge clk_i);
      #2;
      valid_i = 1'b0;
      rst_n_i = 1'b1;
      @(posedge clk_i);
      #2;
      readA(4'd7, 64'd0, "midrst_r7_absent");

      // Memory fault halts with ADR; later writes are ignored.
      applyStimulus(1'b1, 3'd1, 1'b0, 4'd8, 64'h88, 4'hF, 64'd0);
      applyStimulus(1'b1, 3'd1, 1'b1, 4'd3, 64'd5, 4'hF, 64'd0);
      checkOutput("adr_stat", 64'(stat_o), 64'd3);
      checkOutput("adr_halted", 64'(halted_o), 64'd1);
      readA(4'd3, 64'd0, "adr_r3");
      checkOutput("adr_retired", retired_o, 64'd1);
      applyStimulus(1'b1, 3'd1, 1'b0, 4'd9, 64'd9, 4'hF, 64'd0);
      readA(4'd9, 64'd0, "halted_r9");
      checkOutput("halted_retired", retired_o, 64'd1);
      applyStimulus(1'b1, 3'd2, 1'b0, 4'hF, 64'd0, 4'hF, 64'd0);
      checkOutput("halted_stat_held", 64'(stat_o), 64'd3);

      // Out-of-range status values latch as INS; plain ADR latches as ADR.
      pulseReset();
      applyStimulus(1'b1, 3'd0, 1'b0, 4'hF, 64'd0, 4'hF, 64'd0);
      checkOutput("stat0_ins", 64'(stat_o), 64'd4);
      pulseReset();
      applyStimulus(1'b1, 3'd7, 1'b0, 4'hF, 64'd0, 4'hF, 64'd0);
      checkOutput("stat7_ins", 64'(stat_o), 64'd4);
      pulseReset();
      applyStimulus(1'b1, 3'd3, 1'b0, 4'd3, 64'd1, 4'hF, 64'd0);
      checkOutput("stat3_adr", 64'(stat_o), 64'd3);

      // Halt, then reset clears everything.
      pulseReset();
      applyStimulus(1'b1, 3'd1, 1'b0, 4'd10, 64'hAA, 4'd11, 64'hBB);
      applyStimulus(1'b1, 3'd2, 1'b0, 4'd12, 64'hCC, 4'hF, 64'd0);
      checkOutput("hlt_stat", 64'(stat_o), 64'd2);
      checkOutput("hlt_halted", 64'(halted_o), 64'd1);
      checkOutput("hlt_retired", retired_o, 64'd1);
      readA(4'd12, 64'd0, "hlt_r12");
      pulseReset();
      checkOutput("post_rst_stat", 64'(stat_o), 64'd1);
      checkOutput("post_rst_retired", retired_o, 64'd0);
      @(posedge clk_i);
      #2;
      for (int i = 0; i < 16; i++) readA(4'(i), 64'd0, "post_rst_sweep");

      // Mixed pattern run checked against the model every cycle.
      for (int i = 0; i < 24; i++) begin
         srcA_i = 4'((i * 5) % 16);
         srcB_i = 4'((i * 7 + 2) % 16);
         applyStimulus((i % 5) != 4, 3'd1, 1'b0, 4'(i % 16), 64'h1000 + 64'(i),
                       4'((i * 3 + 1) % 16), {32'hDEAD, 32'(i)});
      end
      @(posedge clk_i);
      #2;
      checkOutput("pattern_retired", retired_o, m_retired);

      checks_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

endmodule
